// File: rtl/softplus_squared_stream.sv
// softplus_squared_stream
// Streaming f(x) = softplus(x)^2 on signed Q8.8 samples with valid/ready on
// both sides. Three register stages: classify/lookup (S1), shared multiply
// (S2), combine/saturate into the output register (S3).
// For x in [-3,5) the result is linearly interpolated between integer knots.
// For x >= 5 the result is x*x, clipped to 0x7FFF. For x < -3 it is 0.
// A running counter tracks how many clipped results entered the output register.

module softplus_squared_stream #(
    parameter int DW    = 16,   // Q8.8 signed; only 16 is supported
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);

    typedef enum logic [1:0] {
        KIND_ZERO   = 2'd0,
        KIND_INTERP = 2'd1,
        KIND_SQUARE = 2'd2
    } kind_t;

    // Knots K[-3..5], packed with K[-3] in the least significant slot.
    localparam logic [16*9-1:0] KNOT_ROM = {
        16'h1911, 16'h1025, 16'h094B, 16'h0486, 16'h01BA,
        16'h007B, 16'h0019, 16'h0004, 16'h0001
    };

    // Knot table padded to 16 entries so any 4-bit index is a legal read;
    // only entries 0..8 are ever selected for an interpolated sample.
    logic [15:0] knot [0:15];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_knot
            if (gi < 9) begin : g_rom
                assign knot[gi] = KNOT_ROM[gi*16 +: 16];
            end else begin : g_pad
                assign knot[gi] = 16'h0000;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage occupancy and flow control
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic out_valid_reg;

    logic s3_load;
    logic s2_load;
    logic s1_load;

    // A stage may load when it is empty or its current contents move on.
    // in_ready depends only on register state and out_ready, never on in_valid.
    assign s3_load  = !out_valid_reg || out_ready;
    assign s2_load  = !s2_valid_reg || s3_load;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    // ------------------------------------------------------------------
    // S1: classify the input and fetch knots / multiplier operands
    // ------------------------------------------------------------------
    logic signed [7:0]  x_int;
    logic        [7:0]  x_frac;
    logic        [3:0]  knot_idx;
    logic        [3:0]  knot_idx_hi;
    logic        [15:0] slope;
    kind_t              s1_kind_next;
    logic        [15:0] s1_base_next;
    logic signed [15:0] s1_mul_a_next;
    logic signed [15:0] s1_mul_b_next;

    kind_t              s1_kind_reg;
    logic        [15:0] s1_base_reg;
    logic signed [15:0] s1_mul_a_reg;
    logic signed [15:0] s1_mul_b_reg;
    logic               s1_last_reg;

    // Classification and knot lookup for the incoming sample
    always_comb begin
        x_int         = in_data[15:8];
        x_frac        = in_data[7:0];
        // (i + 3) mod 16 lands on 0..7 for every interpolated i in -3..4
        knot_idx      = in_data[11:8] + 4'd3;
        knot_idx_hi   = knot_idx + 4'd1;
        // Knots are monotonic, so the slope is non-negative and below 2^12
        slope         = knot[knot_idx_hi] - knot[knot_idx];
        s1_kind_next  = KIND_ZERO;
        s1_base_next  = 16'h0000;
        s1_mul_a_next = 16'sh0000;
        s1_mul_b_next = 16'sh0000;
        if (x_int <= -8'sd4) begin
            s1_kind_next = KIND_ZERO;
        end else if (x_int <= 8'sd4) begin
            s1_kind_next  = KIND_INTERP;
            s1_base_next  = knot[knot_idx];
            s1_mul_a_next = slope;
            s1_mul_b_next = {8'h00, x_frac};
        end else begin
            s1_kind_next  = KIND_SQUARE;
            s1_mul_a_next = in_data;
            s1_mul_b_next = in_data;
        end
    end

    // S1 register: holds when S2 cannot take its contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_kind_reg  <= KIND_ZERO;
            s1_base_reg  <= 16'h0000;
            s1_mul_a_reg <= 16'sh0000;
            s1_mul_b_reg <= 16'sh0000;
            s1_last_reg  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_kind_reg  <= s1_kind_next;
                s1_base_reg  <= s1_base_next;
                s1_mul_a_reg <= s1_mul_a_next;
                s1_mul_b_reg <= s1_mul_b_next;
                s1_last_reg  <= in_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: one signed multiplier shared by the interpolate and square paths
    // ------------------------------------------------------------------
    logic signed [31:0] prod_full;
    logic               prod_unused;

    kind_t              s2_kind_reg;
    logic        [15:0] s2_base_reg;
    logic        [23:0] s2_prod_reg;   // product bits [31:8]
    logic               s2_last_reg;

    // Interpolation operands are non-negative, so the signed product equals
    // the unsigned slope*frac product.
    assign prod_full   = 32'(s1_mul_a_reg) * 32'(s1_mul_b_reg);
    // The low 8 product bits are always truncated away by both paths
    assign prod_unused = ^prod_full[7:0];

    // S2 register: captures the product with the sample's kind and base
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_kind_reg  <= KIND_ZERO;
            s2_base_reg  <= 16'h0000;
            s2_prod_reg  <= 24'h000000;
            s2_last_reg  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_kind_reg <= s1_kind_reg;
                s2_base_reg <= s1_base_reg;
                s2_prod_reg <= prod_full[31:8];
                s2_last_reg <= s1_last_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: final result and saturation
    // ------------------------------------------------------------------
    logic [15:0] y_next;
    logic        sat_next;
    logic        sat_inc;

    // Combine base and scaled product, or clip the square to 0x7FFF
    always_comb begin
        y_next   = 16'h0000;
        sat_next = 1'b0;
        case (s2_kind_reg)
            KIND_INTERP: begin
                y_next = s2_base_reg + s2_prod_reg[15:0];
            end
            KIND_SQUARE: begin
                // Product bits [31:23] set means x*x >= 128.0 in Q8.8
                if (|s2_prod_reg[23:15]) begin
                    y_next   = 16'h7FFF;
                    sat_next = 1'b1;
                end else begin
                    y_next = s2_prod_reg[15:0];
                end
            end
            default: begin
                y_next = 16'h0000;
            end
        endcase
    end

    // Output register: data and last hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
        end else if (s3_load) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_data <= y_next;
                out_last <= s2_last_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;

    // Saturated samples are counted when they enter the output register
    assign sat_inc = s3_load && s2_valid_reg && sat_next;

    // Saturation counter: clear has priority, sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (sat_inc && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_softplus_squared_stream.sv
// Testbench for softplus_squared_stream: directed vectors with literal
// expectations, plus a reference model and scoreboard checked every cycle.

module tb_softplus_squared_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit bp_mode = 1'b0;

    // Knot values K[-3..5] in plain integers
    int kn [9] = '{1, 4, 25, 123, 442, 1158, 2379, 4133, 6417};

    typedef struct packed {
        logic        s;
        logic        l;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];

    softplus_squared_stream #(.DW(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    // Reference: returns {saturated, value}
    function automatic logic [16:0] golden(input logic [15:0] x);
        logic signed [7:0] hi;
        int     ip;
        int     fr;
        int     y;
        longint xs;
        longint p;
        logic [16:0] r;
        hi = x[15:8];
        ip = hi;
        fr = int'(x[7:0]);
        xs = longint'($signed(x));
        if (ip <= -4) begin
            r = 17'h00000;
        end else if (ip <= 4) begin
            y = kn[ip+3] + ((kn[ip+4] - kn[ip+3]) * fr) / 256;
            r = {1'b0, 16'(y)};
        end else begin
            p = xs * xs;
            if (p >= 64'sd8388608) r = {1'b1, 16'h7FFF};
            else                   r = {1'b0, 16'(p / 256)};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard, hold check and saturation-count model, sampled mid-cycle
    logic        prev_ov  = 1'b0;
    logic        prev_or  = 1'b1;
    logic [15:0] prev_d   = 16'h0000;
    logic        prev_l   = 1'b0;
    logic        prev_clr = 1'b0;
    logic [15:0] sat_model = 16'h0000;

    always @(negedge clk) begin
        logic [16:0] g;
        exp_t        e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            sat_model = 16'h0000;
            prev_ov   = 1'b0;
            prev_or   = 1'b1;
            prev_clr  = 1'b0;
        end else begin
            if (prev_ov && !prev_or) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_last", 32'(out_last), 32'(prev_l));
            end
            if (prev_clr) begin
                sat_model = 16'h0000;
            end else if (out_valid && (!prev_ov || prev_or) && exp_q.size() > 0) begin
                if (exp_q[0].s && sat_model != 16'hFFFF) sat_model = sat_model + 16'd1;
            end
            chk("sat_cnt", 32'(sat_cnt), 32'(sat_model));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_last", 32'(out_last), 32'(e.l));
                    hs_cyc.push_back(cyc);
                    $display("out #%0d: data=%h last=%b exp=%h", hs_cyc.size(), out_data, out_last, e.d);
                end
            end
            if (in_valid && in_ready) begin
                g = golden(in_data);
                e.s = g[16];
                e.l = in_last;
                e.d = g[15:0];
                exp_q.push_back(e);
            end
            prev_ov  = out_valid;
            prev_or  = out_ready;
            prev_d   = out_data;
            prev_l   = out_last;
            prev_clr = sat_clr;
        end
    end

    // Consumer: always ready, or ~50% random in backpressure mode
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Present one sample; returns 1 time unit after the accepting edge
    task automatic send(input logic [15:0] x, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = x;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Single sample with a hand-computed literal and exact latency check
    task automatic directed(input string name, input logic [15:0] x, input logic [15:0] exp);
        logic [16:0] g;
        g = golden(x);
        chk({"model_", name}, 32'(g[15:0]), 32'(exp));
        send(x, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({name, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(exp));
        chk({name, "_last"}, 32'(out_last), 32'd1);
        drain(20);
    endtask

    initial begin
        int base;
        int t0;
        logic [16:0] g;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single samples
        directed("x0000", 16'h0000, 16'h007B);
        directed("x0080", 16'h0080, 16'h011A);
        directed("xFF80", 16'hFF80, 16'h004A);
        directed("xFD00", 16'hFD00, 16'h0001);
        directed("xFC00", 16'hFC00, 16'h0000);
        directed("x0500", 16'h0500, 16'h1900);

        // Saturation
        directed("x0C00", 16'h0C00, 16'h7FFF);
        chk("sat_cnt_one", 32'(sat_cnt), 32'd1);

        // Reset mid-stream with samples in flight
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0C00, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_output", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Saturation, then clear colliding with a second saturation
        directed("x0C00b", 16'h0C00, 16'h7FFF);
        chk("sat_cnt_again", 32'(sat_cnt), 32'd1);
        send(16'h0C00, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("clr_wins_data", 32'(out_data), 32'h7FFF);
        drain(20);

        // Throughput: 64 back-to-back samples
        base = hs_cyc.size();
        t0   = cyc;
        for (int i = 0; i < 64; i++) send(16'($urandom()), 1'(i == 63));
        chk("tput_in_cycles", 32'(cyc - t0), 32'd64);
        in_valid = 1'b0;
        drain(200);
        chk("tput_count", 32'(hs_cyc.size() - base), 32'd64);
        if (hs_cyc.size() - base == 64)
            chk("tput_span", 32'(hs_cyc[base+63] - hs_cyc[base]), 32'd63);

        // Backpressure with random gaps and random last flags
        bp_mode = 1'b1;
        base = hs_cyc.size();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(16'($urandom()), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        drain(5000);
        bp_mode = 1'b0;
        chk("bp_count", 32'(hs_cyc.size() - base), 32'd1000);
        @(posedge clk);
        #1;

        // Boundaries
        directed("x04FF", 16'h04FF, 16'h1908);
        directed("xFBFF", 16'hFBFF, 16'h0000);
        directed("xFCFF", 16'hFCFF, 16'h0000);
        directed("x7FFF", 16'h7FFF, 16'h7FFF);
        directed("x8000", 16'h8000, 16'h0000);
        g = golden(16'h7FFF);
        chk("model_x7FFF_sat", 32'(g[16]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
